// File: rtl/snac_db15_scanner.sv
// Scans the DB15 adapter's two chained shift registers, publishing glitch-filtered active-high joystick words.
// A new word is only accepted once two consecutive frames agree; dropping i_en aborts the scan and clears everything.
module snac_db15_scanner #(
  parameter int CLK_DIV   = 27,
  parameter int FRAME_GAP = 2000
) (
  input  logic        i_clk,
  input  logic        RESETn,
  input  logic        i_en,
  input  logic        JOY_DATA,
  output logic        JOY_LOAD,
  output logic        JOY_CLK,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        o_frame
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;

  localparam logic [9:0]  DIV_LAST = 10'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(FRAME_GAP - 1);

  state_t      state_q, state_d;
  logic [9:0]  div_q, div_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] raw_q, raw_d;
  logic [31:0] prev_q;
  logic        hist_q;
  logic [1:0]  sync_q;
  logic        load_q, jclk_q, frame_q, done_d;
  logic [15:0] joy1_q, joy2_q;
  logic        tick;

  // The divider is frozen during the single DONE cycle so a frame is an exact
  // number of ticks plus one cycle.
  assign tick = i_en && (state_q != DONE) && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + 10'd1;
    if (!i_en || state_q == DONE || tick) div_d = 10'd0;
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    raw_d   = raw_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (tick) begin
        if (tcnt_q == GAP_LAST) begin
          tcnt_d  = 16'd0;
          state_d = LOAD;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      LOAD: if (tick) begin
        if (tcnt_q == 16'd1) begin
          tcnt_d  = 16'd0;
          bit_d   = 5'd0;
          state_d = SHIFT_LO;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      SHIFT_LO: if (tick) begin
        raw_d[bit_q] = ~sync_q[1];
        state_d      = SHIFT_HI;
      end
      SHIFT_HI: if (tick) begin
        if (bit_q == 5'd31) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          bit_d   = bit_q + 5'd1;
          state_d = SHIFT_LO;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!i_en) begin
      state_d = IDLE;
      tcnt_d  = 16'd0;
      bit_d   = 5'd0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      div_q   <= 10'd0;
      tcnt_q  <= 16'd0;
      bit_q   <= 5'd0;
      raw_q   <= 32'd0;
      prev_q  <= 32'd0;
      hist_q  <= 1'b0;
      sync_q  <= 2'b11;
      load_q  <= 1'b1;
      jclk_q  <= 1'b0;
      frame_q <= 1'b0;
      joy1_q  <= 16'd0;
      joy2_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      bit_q   <= bit_d;
      raw_q   <= raw_d;
      sync_q  <= {sync_q[0], JOY_DATA};
      load_q  <= (state_d != LOAD);
      jclk_q  <= (state_d == SHIFT_HI);
      frame_q <= done_d;
      if (!i_en) begin
        joy1_q <= 16'd0;
        joy2_q <= 16'd0;
        hist_q <= 1'b0;
      end else if (done_d) begin
        // raw_q already holds all 32 bits: bit 31 was captured on the previous low-phase tick.
        if (hist_q && raw_q == prev_q) begin
          joy1_q <= raw_q[15:0];
          joy2_q <= raw_q[31:16];
        end
        prev_q <= raw_q;
        hist_q <= 1'b1;
      end
    end
  end

  assign JOY_LOAD  = load_q;
  assign JOY_CLK   = jclk_q;
  assign o_frame   = frame_q;
  assign joystick1 = joy1_q;
  assign joystick2 = joy2_q;

endmodule

// File: tb/tb_snac_db15_scanner.sv
// Self-checking bench: adapter model plus frame-position reference model compared every cycle.
module tb_snac_db15_scanner;
  localparam int DIV   = 4;
  localparam int GAP   = 8;
  localparam int FRAME = (2 + 64 + GAP) * DIV + 1;
  localparam int SH0   = (GAP + 2) * DIV;

  logic        i_clk = 1'b0;
  logic        RESETn = 1'b0;
  logic        i_en = 1'b0;
  logic        JOY_DATA;
  logic        JOY_LOAD, JOY_CLK, o_frame;
  logic [15:0] joystick1, joystick2;

  snac_db15_scanner #(.CLK_DIV(DIV), .FRAME_GAP(GAP)) dut (
    .i_clk(i_clk), .RESETn(RESETn), .i_en(i_en), .JOY_DATA(JOY_DATA),
    .JOY_LOAD(JOY_LOAD), .JOY_CLK(JOY_CLK),
    .joystick1(joystick1), .joystick2(joystick2), .o_frame(o_frame)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int prints = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
    end
  endtask

  // Adapter: pressed buttons (pat=1) are driven low; load while JOY_LOAD low, shift on JOY_CLK rise.
  logic [31:0] pat = 32'd0;
  logic [31:0] sreg = 32'hFFFF_FFFF;
  logic        aclk_d = 1'b0;
  always @(posedge i_clk) begin
    if (!JOY_LOAD) sreg <= ~pat;
    else if (JOY_CLK && !aclk_d) sreg <= {1'b1, sreg[31:1]};
    aclk_d <= JOY_CLK;
  end
  assign JOY_DATA = sreg[0];

  // Reference: position within the frame is the count of enabled edges since reset/enable.
  int unsigned e_cnt = 0;
  logic [31:0] lat = 32'd0, prev_m = 32'd0, exp_w = 32'd0;
  logic        hist_m = 1'b0;
  always @(posedge i_clk or negedge RESETn) begin
    if (!RESETn || !i_en) begin
      e_cnt  <= 0;
      hist_m <= 1'b0;
      exp_w  <= 32'd0;
    end else begin
      e_cnt <= e_cnt + 1;
      if ((e_cnt + 1) % FRAME == SH0 - 4) lat <= pat;
      if ((e_cnt + 1) % FRAME == FRAME - 1) begin
        if (hist_m && lat == prev_m) exp_w <= lat;
        prev_m <= lat;
        hist_m <= 1'b1;
      end
    end
  end

  int unsigned p;
  logic e_load, e_clk, e_frm, clk_prev = 1'b0;
  int rises = 0, since = 0;
  logic sp_valid = 1'b0;
  always @(negedge i_clk) begin
    p      = e_cnt % FRAME;
    e_load = !(p >= GAP * DIV && p < SH0);
    e_clk  = (p >= SH0) && (p < SH0 + 64 * DIV) && ((((p - SH0) / DIV) % 2) == 1);
    e_frm  = (p == FRAME - 1);
    chk("JOY_LOAD", {31'd0, JOY_LOAD}, {31'd0, e_load});
    chk("JOY_CLK", {31'd0, JOY_CLK}, {31'd0, e_clk});
    chk("o_frame", {31'd0, o_frame}, {31'd0, e_frm});
    chk("joystick1", {16'd0, joystick1}, {16'd0, exp_w[15:0]});
    chk("joystick2", {16'd0, joystick2}, {16'd0, exp_w[31:16]});
    since++;
    if (JOY_CLK && !clk_prev) rises++;
    clk_prev = JOY_CLK;
    if (!RESETn || !i_en) begin
      rises    = 0;
      sp_valid = 1'b0;
      since    = 0;
    end else if (o_frame) begin
      chk("clk_rises", rises, 32);
      if (sp_valid) chk("frame_spacing", since, FRAME);
      rises    = 0;
      since    = 0;
      sp_valid = 1'b1;
    end
  end

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_frame && n < 3 * FRAME);
    if (!o_frame) chk("frame_timeout", 0, 1);
  endtask

  task automatic wait_pos(input int unsigned pos);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while ((e_cnt % FRAME) != pos && n < 3 * FRAME);
    if ((e_cnt % FRAME) != pos) chk("pos_timeout", 0, 1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  int k, low_len;
  logic [31:0] base;
  initial begin
    wait_cycles(3);
    chk("rst_load", {31'd0, JOY_LOAD}, 32'd1);
    chk("rst_clk", {31'd0, JOY_CLK}, 32'd0);
    chk("rst_joy1", {16'd0, joystick1}, 32'd0);
    chk("rst_frame", {31'd0, o_frame}, 32'd0);
    RESETn = 1'b1;
    pat    = $urandom;
    i_en   = 1'b1;

    // Reset during bit 10
    wait_pos(SH0 + 10 * 2 * DIV + 1);
    #2 RESETn = 1'b0;
    #1;
    chk("midrst_load", {31'd0, JOY_LOAD}, 32'd1);
    chk("midrst_clk", {31'd0, JOY_CLK}, 32'd0);
    chk("midrst_joy", {joystick2, joystick1}, 32'd0);
    wait_cycles(3);
    pat    = 32'h0400_0018;
    RESETn = 1'b1;
    k = 0;
    do begin
      @(negedge i_clk);
      k++;
    end while (JOY_LOAD && k < 100);
    chk("load_start", k, 32);
    low_len = 0;
    while (!JOY_LOAD && low_len < 100) begin
      low_len++;
      @(negedge i_clk);
    end
    chk("load_len", low_len, 8);

    // Two identical frames needed
    wait_frame();
    chk("f1_joy1", {16'd0, joystick1}, 32'h0000);
    wait_frame();
    chk("f2_joy1", {16'd0, joystick1}, 32'h0018);
    chk("f2_joy2", {16'd0, joystick2}, 32'h0400);

    // Single-frame glitch on bit 0, then held for two frames
    pat = 32'h0400_0019;
    wait_frame();
    pat = 32'h0400_0018;
    wait_frame();
    chk("glitch_joy1", {16'd0, joystick1}, 32'h0018);
    pat = 32'h0400_0019;
    wait_frame();
    chk("held1_joy1", {16'd0, joystick1}, 32'h0018);
    wait_frame();
    chk("held2_joy1", {16'd0, joystick1}, 32'h0019);

    // Bit order
    pat = 32'h8000_0001;
    wait_frame();
    wait_frame();
    chk("walk_joy1", {16'd0, joystick1}, 32'h0001);
    chk("walk_joy2", {16'd0, joystick2}, 32'h8000);

    // Enable drop during bit 20
    wait_pos(SH0 + 20 * 2 * DIV + 1);
    #2 i_en = 1'b0;
    @(negedge i_clk);
    chk("drop_joy", {joystick2, joystick1}, 32'd0);
    chk("drop_clk", {31'd0, JOY_CLK}, 32'd0);
    chk("drop_load", {31'd0, JOY_LOAD}, 32'd1);
    chk("drop_frame", {31'd0, o_frame}, 32'd0);
    wait_cycles(5);
    pat = 32'h1234_5678;
    #2 i_en = 1'b1;
    wait_frame();
    chk("reen_f1", {joystick2, joystick1}, 32'd0);
    wait_frame();
    chk("reen_f2", {joystick2, joystick1}, 32'h1234_5678);

    // Randomized frames, glitches and enable drops
    for (int f = 0; f < 30; f++) begin
      base = pat;
      case ($urandom_range(9, 0))
        0, 1, 2, 3: wait_frame();
        4, 5, 6: begin
          pat = $urandom;
          wait_frame();
        end
        7, 8: begin
          pat = base ^ (32'd1 << $urandom_range(31, 0));
          wait_frame();
          pat = base;
          wait_frame();
        end
        default: begin
          wait_cycles($urandom_range(280, 1));
          #2 i_en = 1'b0;
          wait_cycles($urandom_range(5, 1));
          #2 i_en = 1'b1;
          wait_frame();
        end
      endcase
    end
    wait_cycles(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
